// File: rtl/inst_mem_loader_pkg.sv
// -----------------------------------------------------------------------------
// inst_mem_loader_pkg
// Shared constants for the boot-loaded instruction store. Holds the reset and
// chip-enable levels, the zero word, the fetch bus widths, the load/run state
// encoding, and the byte-merge helper used to assemble big-endian words.
// -----------------------------------------------------------------------------
package inst_mem_loader_pkg;

  localparam logic        RST_ENABLE  = 1'b1;   // reset asserted level
  localparam logic        CHIP_ENABLE = 1'b1;   // fetch enable asserted level
  localparam int unsigned INST_ADDR_W = 32;     // fetch byte-address width
  localparam int unsigned INST_W      = 32;     // instruction word width
  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  // LOAD is the reset state; RUN is terminal until the next reset.
  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } load_state_e;

  // Place a byte into the word at lane 'pos', big-endian: lane 0 is bits 31:24.
  // Lanes not yet filled keep whatever 'word' holds (zero after a word starts).
  function automatic logic [INST_W-1:0] merge_byte(input logic [INST_W-1:0] word,
                                                   input logic [1:0]        pos,
                                                   input logic [7:0]        data);
    logic [INST_W-1:0] res;
    res = word;
    case (pos)
      2'd0:    res[31:24] = data;
      2'd1:    res[23:16] = data;
      2'd2:    res[15:8]  = data;
      default: res[7:0]   = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/inst_mem_loader_array.sv
// -----------------------------------------------------------------------------
// inst_mem_array
// Instruction store: one synchronous write port, one asynchronous read port.
// Contents start at zero from power-up and are never cleared by reset.
//
// Ports
//   clk      in   write clock
//   i_we     in   write enable
//   i_waddr  in   write word index
//   i_wdata  in   write data
//   i_raddr  in   read word index
//   o_rdata  out  read data (combinational)
// -----------------------------------------------------------------------------
module inst_mem_array
  import inst_mem_loader_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [INST_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [INST_W-1:0] o_rdata
);

  // NOTE: the storage array has no reset branch; clearing a RAM on reset would
  // force it into flops. Zero contents come from the declaration initialiser,
  // which applies once at configuration/power-up only.
  logic [INST_W-1:0] r_mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_mem_loader.sv
// -----------------------------------------------------------------------------
// inst_mem_loader
// Instruction store that is filled from a byte stream after reset and then
// serves processor fetches. While loading, the processor is held via
// stall_req; once the byte flagged ld_last arrives the block switches to RUN
// and answers fetches combinationally.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   ce         in   fetch enable from the fetch stage
//   addr       in   fetch byte address (32)
//   inst       out  fetched instruction word (32), zero when not serving
//   ld_valid   in   loader byte valid
//   ld_data    in   loader byte (8)
//   ld_last    in   final byte of the image (with ld_valid)
//   ld_ready   out  loader may transfer this cycle
//   stall_req  out  hold processor while loading
//   boot_done  out  image complete, fetches are served
//   ld_err     out  sticky: image overflowed the store
// -----------------------------------------------------------------------------
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int INST_MEM_NUM      = 1024,
  parameter int INST_MEM_NUM_LOG2 = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic [INST_ADDR_W-1:0] addr,
  output logic [INST_W-1:0]      inst,
  input  logic                   ld_valid,
  input  logic [7:0]             ld_data,
  input  logic                   ld_last,
  output logic                   ld_ready,
  output logic                   stall_req,
  output logic                   boot_done,
  output logic                   ld_err
);

  localparam int AW = INST_MEM_NUM_LOG2;

  load_state_e         r_state;
  load_state_e         w_state_nxt;
  logic [1:0]          r_bcnt;
  logic [AW:0]         r_wptr;      // one extra bit so "full" is representable
  logic [INST_W-1:0]   r_asm;
  logic                r_ld_err;

  logic                w_xfer;
  logic                w_word_end;
  logic                w_full;
  logic                w_we;
  logic [INST_W-1:0]   w_word;
  logic [INST_W-1:0]   w_rdata;
  logic                w_in_range;
  logic                w_unused_lsbs;

  // A completed or final word is written unless every slot is already used.
  assign w_full     = (r_wptr == (AW+1)'(INST_MEM_NUM));
  assign w_xfer     = ld_valid && ld_ready && (rst != RST_ENABLE);
  assign w_word_end = (r_bcnt == 2'd3) || ld_last;
  assign w_we       = w_xfer && w_word_end && !w_full;

  // Assembly register is zero at the start of each word, so a short final
  // word comes out zero-padded in its unfilled low bytes.
  assign w_word = merge_byte(r_asm, r_bcnt, ld_data);

  // ---------------------------------------------------------------------------
  // FSM: next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    ld_ready    = 1'b0;
    stall_req   = 1'b0;
    boot_done   = 1'b0;
    case (r_state)
      ST_LOAD: begin
        ld_ready  = 1'b1;
        stall_req = 1'b1;
        if (w_xfer && ld_last) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        boot_done = 1'b1;
      end
      default: begin
        w_state_nxt = ST_LOAD;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and loader datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      r_state  <= ST_LOAD;
      r_bcnt   <= 2'd0;
      r_wptr   <= '0;
      r_asm    <= ZERO_WORD;
      r_ld_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        // Bytes arriving once the store is full are dropped and flagged.
        if (w_full) begin
          r_ld_err <= 1'b1;
        end
        if (w_word_end) begin
          r_bcnt <= 2'd0;
          r_asm  <= ZERO_WORD;
        end else begin
          r_bcnt <= r_bcnt + 2'd1;
          r_asm  <= w_word;
        end
        if (w_we) begin
          r_wptr <= r_wptr + (AW+1)'(1);
        end
      end
    end
  end

  assign ld_err = r_ld_err;

  // ---------------------------------------------------------------------------
  // Storage and fetch port
  // ---------------------------------------------------------------------------
  inst_mem_array #(
    .DEPTH (INST_MEM_NUM),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wptr[AW-1:0]),
    .i_wdata (w_word),
    .i_raddr (addr[AW+1:2]),
    .o_rdata (w_rdata)
  );

  // Addresses beyond the store read as zero instead of aliasing onto it.
  assign w_in_range = (addr[INST_ADDR_W-1:AW+2] == '0);

  // Byte-lane bits are intentionally ignored: fetches are word aligned.
  assign w_unused_lsbs = ^addr[1:0];

  always_comb begin
    inst = ZERO_WORD;
    if ((ce == CHIP_ENABLE) && boot_done && w_in_range) begin
      inst = w_rdata;
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_inst_mem_loader
// Directed bench. dut_a uses the default 1024-word store; dut_b uses a 4-word
// store to exercise overflow. Both share the same stimulus.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic [31:0] addr = '0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = '0;
  logic        ld_last = 1'b0;

  logic [31:0] a_inst, b_inst;
  logic        a_ready, a_stall, a_done, a_err;
  logic        b_ready, b_stall, b_done, b_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  inst_mem_loader dut_a (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(a_inst),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(a_ready), .stall_req(a_stall), .boot_done(a_done), .ld_err(a_err)
  );

  inst_mem_loader #(.INST_MEM_NUM(4), .INST_MEM_NUM_LOG2(2)) dut_b (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(b_inst),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(b_ready), .stall_req(b_stall), .boot_done(b_done), .ld_err(b_err)
  );

  // One byte transfer; returns 1ns after the capturing edge.
  task automatic send(input logic [7:0] d, input logic last);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_data  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic fetch(input logic [31:0] a);
    ce   = 1'b1;
    addr = a;
    #1;
  endtask

  task automatic test_reset();
    // rst is high from time 0; offer a "last" byte that must be refused.
    @(negedge clk);
    ld_valid = 1'b1; ld_data = 8'h99; ld_last = 1'b1; ce = 1'b1; addr = '0;
    @(posedge clk);
    #1;
    n_checks++; if (a_ready !== 1'b1) $display("FAIL reset_ld_ready got %b want 1", a_ready); else n_pass++;
    n_checks++; if (a_stall !== 1'b1) $display("FAIL reset_stall_req got %b want 1", a_stall); else n_pass++;
    n_checks++; if (a_done !== 1'b0) $display("FAIL reset_boot_done got %b want 0", a_done); else n_pass++;
    n_checks++; if (a_err !== 1'b0) $display("FAIL reset_ld_err got %b want 0", a_err); else n_pass++;
    n_checks++; if (a_inst !== 32'h0) $display("FAIL reset_inst got %h want 00000000", a_inst); else n_pass++;
    ld_valid = 1'b0; ld_last = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (a_done !== 1'b0) $display("FAIL reset_no_xfer_boot_done got %b want 0", a_done); else n_pass++;
    ce = 1'b0;
  endtask

  task automatic test_basic_load();
    logic [7:0] img [8];
    img = '{8'h34, 8'h01, 8'h00, 8'h10, 8'h24, 8'h02, 8'h00, 8'h20};
    for (int i = 0; i < 7; i++) send(img[i], 1'b0);
    n_checks++; if (a_done !== 1'b0) $display("FAIL basic_done_early got %b want 0", a_done); else n_pass++;
    send(img[7], 1'b1);
    n_checks++; if (a_done !== 1'b1) $display("FAIL basic_boot_done got %b want 1", a_done); else n_pass++;
    n_checks++; if (a_ready !== 1'b0) $display("FAIL basic_ld_ready got %b want 0", a_ready); else n_pass++;
    n_checks++; if (a_stall !== 1'b0) $display("FAIL basic_stall_req got %b want 0", a_stall); else n_pass++;
    fetch(32'h4);
    n_checks++; if (a_inst !== 32'h24020020) $display("FAIL basic_fetch4 got %h want 24020020", a_inst); else n_pass++;
    fetch(32'h0);
    n_checks++; if (a_inst !== 32'h34010010) $display("FAIL basic_fetch0 got %h want 34010010", a_inst); else n_pass++;
    fetch(32'h7);
    n_checks++; if (a_inst !== 32'h24020020) $display("FAIL basic_fetch_unaligned got %h want 24020020", a_inst); else n_pass++;
  endtask

  task automatic test_fetch_gating();
    ce = 1'b0; addr = 32'h0; #1;
    n_checks++; if (a_inst !== 32'h0) $display("FAIL gate_ce0 got %h want 00000000", a_inst); else n_pass++;
    fetch(32'h0000_1000);
    n_checks++; if (a_inst !== 32'h0) $display("FAIL gate_out_of_range got %h want 00000000", a_inst); else n_pass++;
    ce = 1'b0;
  endtask

  task automatic test_partial();
    do_reset();
    fetch(32'h0);
    n_checks++; if (a_inst !== 32'h0) $display("FAIL partial_load_fetch got %h want 00000000", a_inst); else n_pass++;
    ce = 1'b0;
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b1);
    n_checks++; if (a_done !== 1'b1) $display("FAIL partial_boot_done got %b want 1", a_done); else n_pass++;
    n_checks++; if (a_ready !== 1'b0) $display("FAIL partial_ld_ready got %b want 0", a_ready); else n_pass++;
    // RUN ignores further loader traffic.
    send(8'hDD, 1'b1);
    fetch(32'h0);
    n_checks++; if (a_inst !== 32'hAABBCC00) $display("FAIL partial_word0 got %h want AABBCC00", a_inst); else n_pass++;
    fetch(32'h4);
    n_checks++; if (a_inst !== 32'h24020020) $display("FAIL partial_word1_kept got %h want 24020020", a_inst); else n_pass++;
    ce = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      send(8'(i), (i == 20));
      if (i == 16) begin
        n_checks++; if (b_err !== 1'b0) $display("FAIL ovf_err_after16 got %b want 0", b_err); else n_pass++;
      end
      if (i == 17) begin
        n_checks++; if (b_err !== 1'b1) $display("FAIL ovf_err_after17 got %b want 1", b_err); else n_pass++;
      end
    end
    n_checks++; if (b_done !== 1'b1) $display("FAIL ovf_boot_done got %b want 1", b_done); else n_pass++;
    n_checks++; if (b_err !== 1'b1) $display("FAIL ovf_err_sticky got %b want 1", b_err); else n_pass++;
    n_checks++; if (a_err !== 1'b0) $display("FAIL ovf_big_store_err got %b want 0", a_err); else n_pass++;
    fetch(32'h0);
    n_checks++; if (b_inst !== 32'h01020304) $display("FAIL ovf_word0 got %h want 01020304", b_inst); else n_pass++;
    fetch(32'hC);
    n_checks++; if (b_inst !== 32'h0D0E0F10) $display("FAIL ovf_word3 got %h want 0D0E0F10", b_inst); else n_pass++;
    fetch(32'h10);
    n_checks++; if (b_inst !== 32'h0) $display("FAIL ovf_out_of_range got %h want 00000000", b_inst); else n_pass++;
    n_checks++; if (a_inst !== 32'h11121314) $display("FAIL ovf_big_word4 got %h want 11121314", a_inst); else n_pass++;
    ce = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] junk [6];
    junk = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
    do_reset();
    for (int i = 0; i < 6; i++) send(junk[i], 1'b0);
    do_reset();
    n_checks++; if (a_ready !== 1'b1) $display("FAIL midrst_ld_ready got %b want 1", a_ready); else n_pass++;
    n_checks++; if (a_stall !== 1'b1) $display("FAIL midrst_stall_req got %b want 1", a_stall); else n_pass++;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    n_checks++; if (a_done !== 1'b1) $display("FAIL midrst_boot_done got %b want 1", a_done); else n_pass++;
    fetch(32'h0);
    n_checks++; if (a_inst !== 32'h11223344) $display("FAIL midrst_word0 got %h want 11223344", a_inst); else n_pass++;
    fetch(32'h4);
    n_checks++; if (a_inst !== 32'h05060708) $display("FAIL midrst_word1_kept got %h want 05060708", a_inst); else n_pass++;
    ce = 1'b0;
  endtask

  task automatic test_gaps();
    logic [7:0] img [8];
    int gap [8];
    img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    gap = '{0, 2, 1, 3, 0, 10, 1, 2};  // idle cycles before each byte
    do_reset();
    for (int i = 0; i < 8; i++) begin
      repeat (gap[i]) @(negedge clk);
      if (i == 5) begin
        n_checks++; if (a_done !== 1'b0) $display("FAIL gaps_done_in_gap got %b want 0", a_done); else n_pass++;
      end
      send(img[i], (i == 7));
    end
    n_checks++; if (a_done !== 1'b1) $display("FAIL gaps_boot_done got %b want 1", a_done); else n_pass++;
    fetch(32'h0);
    n_checks++; if (a_inst !== 32'hDEADBEEF) $display("FAIL gaps_word0 got %h want DEADBEEF", a_inst); else n_pass++;
    fetch(32'h4);
    n_checks++; if (a_inst !== 32'h01234567) $display("FAIL gaps_word1 got %h want 01234567", a_inst); else n_pass++;
    fetch(32'h8);
    n_checks++; if (a_inst !== 32'h090A0B0C) $display("FAIL gaps_word2_kept got %h want 090A0B0C", a_inst); else n_pass++;
    ce = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_fetch_gating();
    test_partial();
    test_overflow();
    test_reset_mid_load();
    test_gaps();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
